// File: rtl/rvb_pkg.sv
// rtl/rvb_pkg.sv - shared encodings and entry control bits for the shifter issue stage
package rvb_pkg;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;

    localparam logic [2:0] F3_SL  = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_BFP = 3'b111;

    // single-bit op groups and the bit-field-place pattern
    localparam logic [6:0] F7_SBSET = 7'h14;
    localparam logic [6:0] F7_SBCLR = 7'h24;
    localparam logic [6:0] F7_SBINV = 7'h34;
    localparam logic [6:0] F7_BFP   = 7'h24;

    typedef struct packed {
        logic insn3;
        logic insn13;
        logic insn14;
        logic insn26;
        logic insn27;
        logic insn29;
        logic insn30;
    } ctl_t;

endpackage

// File: rtl/rvb_shifter_issue_if.sv
// rtl/rvb_shifter_issue_if.sv - instruction-in, shifter-out and error-strobe signals of the issue stage
interface rvb_shifter_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_rs3;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rs1;
    logic [XLEN-1:0] out_rs2;
    logic [XLEN-1:0] out_rs3;
    logic            out_insn3;
    logic            out_insn13;
    logic            out_insn14;
    logic            out_insn26;
    logic            out_insn27;
    logic            out_insn29;
    logic            out_insn30;

    logic            err_valid;
    logic [31:0]     err_insn;

    modport master (
        output in_valid, in_insn, in_rs1, in_rs2, in_rs3, out_ready,
        input  in_ready, out_valid, out_rs1, out_rs2, out_rs3,
        input  out_insn3, out_insn13, out_insn14, out_insn26, out_insn27, out_insn29, out_insn30,
        input  err_valid, err_insn
    );

    modport slave (
        input  in_valid, in_insn, in_rs1, in_rs2, in_rs3, out_ready,
        output in_ready, out_valid, out_rs1, out_rs2, out_rs3,
        output out_insn3, out_insn13, out_insn14, out_insn26, out_insn27, out_insn29, out_insn30,
        output err_valid, err_insn
    );
endinterface

// File: rtl/rvb_issue_decode.sv
// rtl/rvb_issue_decode.sv - combinational shifter-legality check and control-bit extraction
module rvb_issue_decode
    import rvb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SBOP = 0,
    parameter int BFP  = 0
) (
    input  logic [6:0] i_funct7,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_opcode,
    output logic       o_legal,
    output ctl_t       o_ctl
);
    logic w_rr;
    logic w_ri;
    logic w_f3_ok;
    logic w_mext;
    logic w_sb;
    logic w_bfp;

    assign w_rr    = (i_opcode == OPC_OP)    || ((XLEN == 64) && (i_opcode == OPC_OP32));
    assign w_ri    = (i_opcode == OPC_OPIMM) || ((XLEN == 64) && (i_opcode == OPC_OPIMM32));
    assign w_f3_ok = (i_funct3 == F3_SL) || (i_funct3 == F3_SR);
    // funct7[1:0]==01 on register-register opcodes is the M extension
    assign w_mext  = w_rr && (i_funct7[1:0] == 2'b01);
    assign w_sb    = (i_funct7 == F7_SBSET) || (i_funct7 == F7_SBCLR) || (i_funct7 == F7_SBINV);
    assign w_bfp   = (i_opcode == OPC_OP) && (i_funct7 == F7_BFP) && (i_funct3 == F3_BFP);

    assign o_legal = (w_rr || w_ri) && w_f3_ok && !w_mext
                   && !((SBOP == 0) && w_sb)
                   && !((BFP == 0) && w_bfp);

    assign o_ctl.insn3  = (XLEN == 64) ? i_opcode[3] : 1'b0;
    assign o_ctl.insn13 = i_funct3[1];
    assign o_ctl.insn14 = i_funct3[2];
    assign o_ctl.insn26 = i_funct7[1];
    assign o_ctl.insn27 = i_funct7[2];
    assign o_ctl.insn29 = i_funct7[4];
    assign o_ctl.insn30 = i_funct7[5];

endmodule

// File: rtl/rvb_shifter_issue.sv
// rtl/rvb_shifter_issue.sv - 2-entry issue buffer in front of rvb_shifter with illegal-instruction strobe
module rvb_shifter_issue
    import rvb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SBOP = 0,
    parameter int BFP  = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    rvb_shifter_issue_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] rs3;
        ctl_t            ctl;
    } entry_t;

    entry_t      r_mem [2];
    entry_t      r_head;
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic        r_err_valid;
    logic [31:0] r_err_insn;

    logic        w_legal;
    ctl_t        w_ctl;
    entry_t      w_entry;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_enq;
    logic        w_deq;
    logic        w_illegal;
    logic        w_rd_nxt;
    logic [1:0]  w_count_nxt;

    rvb_issue_decode #(
        .XLEN (XLEN),
        .SBOP (SBOP),
        .BFP  (BFP)
    ) u_decode (
        .i_funct7 (bus.in_insn[31:25]),
        .i_funct3 (bus.in_insn[14:12]),
        .i_opcode (bus.in_insn[6:0]),
        .o_legal  (w_legal),
        .o_ctl    (w_ctl)
    );

    assign w_entry     = {bus.in_rs1, bus.in_rs2, bus.in_rs3, w_ctl};
    assign w_in_ready  = (r_count != 2'd2);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_enq       = w_accept && w_legal;
    assign w_illegal   = w_accept && !w_legal;
    assign w_deq       = (r_count != 2'd0) && bus.out_ready;
    assign w_rd_nxt    = r_rd_ptr ^ w_deq;
    assign w_count_nxt = r_count + {1'b0, w_enq} - {1'b0, w_deq};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_head      <= '0;
            r_count     <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_insn  <= '0;
        end else begin
            r_err_valid <= w_illegal && !flush;
            if (w_illegal && !flush) begin
                r_err_insn <= bus.in_insn;
            end
            if (flush) begin
                r_count  <= 2'd0;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_mem[r_wr_ptr] <= w_entry;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                r_rd_ptr <= w_rd_nxt;
                r_count  <= w_count_nxt;
                // the output register tracks the next head; an empty buffer keeps the last one shown
                if (w_count_nxt != 2'd0) begin
                    r_head <= (w_enq && (r_wr_ptr == w_rd_nxt)) ? w_entry : r_mem[w_rd_nxt];
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.out_rs1    = r_head.rs1;
    assign bus.out_rs2    = r_head.rs2;
    assign bus.out_rs3    = r_head.rs3;
    assign bus.out_insn3  = r_head.ctl.insn3;
    assign bus.out_insn13 = r_head.ctl.insn13;
    assign bus.out_insn14 = r_head.ctl.insn14;
    assign bus.out_insn26 = r_head.ctl.insn26;
    assign bus.out_insn27 = r_head.ctl.insn27;
    assign bus.out_insn29 = r_head.ctl.insn29;
    assign bus.out_insn30 = r_head.ctl.insn30;
    assign bus.err_valid  = r_err_valid;
    assign bus.err_insn   = r_err_insn;

endmodule

// File: doc/rvb_shifter_issue.md
Name: rvb_shifter_issue

Overview:
- Issue stage directly upstream of rvb_shifter.
- Accepts raw 32-bit instructions plus rs1/rs2/rs3 from the decode/regfile stage.
- Classifies each instruction as shifter-legal or illegal. Legal instructions are buffered in a 2-entry FIFO and presented on the shifter's din_* valid/ready interface, with the instruction control bits already extracted. Illegal instructions are consumed and reported on a one-cycle error strobe.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- SBOP, 0, single-bit ops enabled in the downstream shifter; when 0, funct7 patterns 0x14/0x24/0x34 are illegal.
- BFP, 0, bfp enabled downstream; when 0, the bfp pattern is illegal.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  issue stage can accept
- in_insn  in  32  raw instruction word
- in_rs1, in_rs2, in_rs3  in  XLEN each  operands
- out_valid  out  1  to shifter din_valid
- out_ready  in  1  from shifter din_ready
- out_rs1, out_rs2, out_rs3  out  XLEN each  operands of head entry
- out_insn3, out_insn13, out_insn14, out_insn26, out_insn27, out_insn29, out_insn30  out  1 each  insn bits of head entry
- err_valid  out  1  one-cycle illegal-instruction strobe
- err_insn  out  32  offending instruction word; valid when err_valid=1

Behaviour:
- Reset (reset=0 at posedge): count=0, rd/wr pointers=0, out_valid=0, err_valid=0, err_insn=0, all out_* data=0.
- in_ready = (count < 2). Purely a function of registered count; never depends on out_ready.
- Accept = in_valid && in_ready.
- Legality (combinational on in_insn), all conditions required:
  - opcode in {0110011, 0010011}, or additionally {0111011, 0011011} when XLEN==64;
  - funct3 in {001, 101};
  - for register-register opcodes, insn[26:25] != 01 (M-extension excluded);
  - the SBOP and BFP gating above applies.
- Legal accept: writes entry {rs1, rs2, rs3, insn bits} at wr_ptr.
  - out_insn3 is stored as insn[3] when XLEN==64, else constant 0.
  - Operands are truncated to XLEN.
- Illegal accept: no enqueue. Next cycle err_valid=1 and err_insn=word; both are held for exactly 1 cycle. Back-to-back illegal instructions strobe on consecutive cycles.
- Dequeue = out_valid && out_ready; advances rd_ptr.
- out_valid = (count != 0). out_* are driven from the head entry and stay stable while out_valid && !out_ready.
- Latency: a legal instruction accepted at edge N appears on out_* from edge N (i.e. cycle N+1) when the FIFO was empty. Sustained throughput is 1/cycle with out_ready=1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is allowed at count=1; at count=2 no enqueue occurs because in_ready=0.
- Pointer wrap: 1-bit pointers wrap modulo 2.
- Full (count=2): in_ready=0 and the input is held. Empty: out_valid=0 and out_* keep their last values (not re-zeroed).
- flush=1: count=0 and pointers=0 next cycle. Any same-cycle accept is dropped, including the illegal err strobe. Any same-cycle dequeue is counted as completed by the shifter.
- reset mid-operation: buffered entries are lost with no err strobe. Reset has priority over flush.

Decomposition:
- Package rvb_pkg:
  - opcode constants OPC_OP, OPC_OPIMM, OPC_OP32, OPC_OPIMM32;
  - funct3 constants F3_SL, F3_SR;
  - funct7 pattern constants for the SBOP/BFP groups;
  - struct/typedef for a buffer entry (operands + 7 control bits).
- Sub-module rvb_issue_decode: combinational legality check and control-bit extraction.
- FIFO and err logic remain in the top module.

Test Plan:
- Reset, then in_valid=1 with insn=0x00209093 (slli x1,x1,2) and rs1=0x1, out_ready=1 -> out_valid=1 next cycle, out_rs1=0x1, out_insn14=0, out_insn13=0. No err.
- out_ready=0; issue 3 legal instructions back-to-back -> in_ready falls to 0 after the 2nd accept and the 3rd is held. Raise out_ready -> entries emerge in order at 1/cycle and the 3rd is then accepted.
- insn=0x0220D0B3 (divu, M-ext) -> in_ready stays 1, no enqueue, err_valid=1 for one cycle with err_insn=0x0220D0B3.
- SBOP=0: insn=0x4820D0B3 (funct7 0x24) -> err; SBOP=1: same insn -> enqueued with out_insn30=1, out_insn27=1.
- FIFO holds 2 entries, flush=1 with a concurrent legal in_valid -> next cycle out_valid=0, count=0, input dropped, err_valid=0.
- XLEN=32, insn with bit3=1 (opcode 0111011) -> illegal err; XLEN=64, same insn -> enqueued with out_insn3=1.
